gray_counter_param: RTL and testbench
=====================================

Name: gray_counter_param

Overview:
- Parametrised Gray-code counter, the successor to the fixed 3-bit up-only Gray counter.
- Adds:
  - configurable width;
  - up/down counting;
  - synchronous parallel load;
  - a parallel binary view of the count;
  - separate sticky overflow and underflow flags with a clear input;
  - a one-cycle wrap strobe.
- Used wherever a single-bit-change count sequence is needed, e.g. FIFO pointers, debounced position counters and lab sequence generators.

Parameters:
- WIDTH, 4, counter width in bits; legal range 2..16.
- STICKY, 1, 1 = Overflow/Underflow hold until cleared; 0 = they pulse for one cycle per wrap event.

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  synchronous, active-high reset, sampled on rising Clk.
- En  input  1  count enable; one step per cycle while high.
- Dir  input  1  1 = count up, 0 = count down.
- Load  input  1  synchronous parallel load strobe.
- LoadVal  input  WIDTH  binary value to load.
- ClrFlags  input  1  clears Overflow/Underflow (only meaningful when STICKY=1).
- Output  output  WIDTH  registered Gray-coded count.
- Binary  output  WIDTH  registered binary count, always consistent with Output.
- Overflow  output  1  up-count wrap from all-ones to zero.
- Underflow  output  1  down-count wrap from zero to all-ones.
- Wrap  output  1  registered one-cycle pulse on either wrap.

Behaviour:
- State is a WIDTH-bit binary register B.
  - Output = B ^ (B >> 1), registered alongside B; no combinational path from inputs to outputs.
  - All outputs change only on a rising Clk edge; latency from input to output is 1 cycle.
- Reset (synchronous, highest priority): B=0, Output=0, Binary=0, Overflow=0, Underflow=0, Wrap=0.
  - Reset mid-count discards the count and all flags on that edge.
  - Power-on state is the same as the reset state.
- Priority per edge: Reset > Load > En. Dir is ignored when En=0.
- Load=1:
  - B <= LoadVal, regardless of En.
  - Wrap <= 0. No flag is set by a load, even if LoadVal equals a boundary value.
- En=1, Load=0, Dir=1:
  - B <= B+1, modulo 2^WIDTH.
  - If B was all-ones: B <= 0, Overflow event, Wrap <= 1.
- En=1, Load=0, Dir=0:
  - B <= B-1, modulo 2^WIDTH.
  - If B was 0: B <= all-ones, Underflow event, Wrap <= 1.
- En=0, Load=0: B holds; Wrap <= 0.
- Successive Output values while counting differ in exactly one bit, in both directions and across the wrap.
- Flags with STICKY=1:
  - An event sets its flag, and the flag holds until ClrFlags=1 or Reset.
  - If ClrFlags and a new event of the same kind occur on the same edge, the set wins (flag = 1).
  - Overflow and Underflow are independent; both may be 1 at once.
- Flags with STICKY=0:
  - Each flag equals its event registered for exactly one cycle.
  - ClrFlags has no effect.
- Wrap is never sticky, regardless of STICKY.
- Dir may change on any cycle; the next step uses the Dir value sampled on that edge.

Test Plan:
1. WIDTH=3, Reset then En=1, Dir=1 for 8 cycles:
   - Output sequence: 001, 011, 010, 110, 111, 101, 100, 000.
   - Overflow=1 and Wrap=1 on the 8th edge; Wrap=0 on the next cycle with Overflow still 1.
   - Every step has Hamming distance 1.
2. WIDTH=4, from reset, En=1, Dir=0 for one cycle:
   - Binary=1111, Output=1000, Underflow=1, Wrap=1, Overflow=0.
3. WIDTH=4, Load=1 with LoadVal=0101 while En=1, Dir=1:
   - Next cycle Binary=0101, Output=0111, no flags.
   - Then one En cycle gives Binary=0110, Output=0101.
4. WIDTH=4, STICKY=1, Load 1111, then En=1, Dir=1 with ClrFlags=1 on that same edge:
   - Overflow=1, because set beats clear.
   - ClrFlags alone on the next cycle gives Overflow=0.
5. WIDTH=4, STICKY=0, count up through the wrap:
   - Overflow high for exactly one cycle; ClrFlags ignored.
6. WIDTH=4, Reset asserted mid-count at Binary=1010 with En=1 and Load=1:
   - Next cycle all outputs are 0.
   - With En=0 held afterwards, Output stays 0000.

Source files
------------

// File: rtl/gray_counter_param.sv
// Parametrised up/down Gray-code counter with parallel load, a registered binary view,
// overflow/underflow flags (sticky or pulsed) and a one-cycle wrap strobe.
module gray_counter_param #(
    parameter int WIDTH  = 4,
    parameter bit STICKY = 1'b1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             En,
    input  logic             Dir,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             ClrFlags,
    output logic [WIDTH-1:0] Output,
    output logic [WIDTH-1:0] Binary,
    output logic             Overflow,
    output logic             Underflow,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

    logic [WIDTH-1:0] r_bin;
    logic [WIDTH-1:0] r_gray;
    logic             r_ovf;
    logic             r_unf;
    logic             r_wrap;

    logic [WIDTH-1:0] w_next_bin;
    logic [WIDTH-1:0] w_next_gray;
    logic             w_ovf_evt;
    logic             w_unf_evt;
    logic             w_next_ovf;
    logic             w_next_unf;

    // Load beats counting; wrap events only come from an enabled step.
    always_comb begin
        w_next_bin = r_bin;
        w_ovf_evt  = 1'b0;
        w_unf_evt  = 1'b0;
        if (Load) begin
            w_next_bin = LoadVal;
        end else if (En) begin
            if (Dir) begin
                w_next_bin = r_bin + ONE;
                w_ovf_evt  = (r_bin == ALL_ONES);
            end else begin
                w_next_bin = r_bin - ONE;
                w_unf_evt  = (r_bin == '0);
            end
        end
    end

    // Gray code is derived from the next binary value so both views update on the same edge.
    always_comb begin
        w_next_gray = w_next_bin ^ (w_next_bin >> 1);
        if (STICKY) begin
            w_next_ovf = w_ovf_evt | (r_ovf & ~ClrFlags);
            w_next_unf = w_unf_evt | (r_unf & ~ClrFlags);
        end else begin
            w_next_ovf = w_ovf_evt;
            w_next_unf = w_unf_evt;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_bin  <= '0;
            r_gray <= '0;
            r_ovf  <= 1'b0;
            r_unf  <= 1'b0;
            r_wrap <= 1'b0;
        end else begin
            r_bin  <= w_next_bin;
            r_gray <= w_next_gray;
            r_ovf  <= w_next_ovf;
            r_unf  <= w_next_unf;
            r_wrap <= w_ovf_evt | w_unf_evt;
        end
    end

    assign Output    = r_gray;
    assign Binary    = r_bin;
    assign Overflow  = r_ovf;
    assign Underflow = r_unf;
    assign Wrap      = r_wrap;

endmodule

// File: tb/tb_gray_counter_param.sv
// Bench for gray_counter_param: three instances (4-bit sticky, 4-bit pulsed, 3-bit sticky)
// driven in parallel and checked against a table, hand sequences and a reference model.
module tb_gray_counter_param;

    logic       clk = 1'b0;
    logic       rst, en, dir, load, clr;
    logic [3:0] lv;

    logic [3:0] g0, b0, g1, b1;
    logic [2:0] g2, b2;
    logic       o0, u0, w0, o1, u1, w1, o2, u2, w2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    gray_counter_param #(.WIDTH(4), .STICKY(1'b1)) dut0 (
        .Clk(clk), .Reset(rst), .En(en), .Dir(dir), .Load(load), .LoadVal(lv),
        .ClrFlags(clr), .Output(g0), .Binary(b0), .Overflow(o0), .Underflow(u0), .Wrap(w0)
    );
    gray_counter_param #(.WIDTH(4), .STICKY(1'b0)) dut1 (
        .Clk(clk), .Reset(rst), .En(en), .Dir(dir), .Load(load), .LoadVal(lv),
        .ClrFlags(clr), .Output(g1), .Binary(b1), .Overflow(o1), .Underflow(u1), .Wrap(w1)
    );
    gray_counter_param #(.WIDTH(3), .STICKY(1'b1)) dut2 (
        .Clk(clk), .Reset(rst), .En(en), .Dir(dir), .Load(load), .LoadVal(lv[2:0]),
        .ClrFlags(clr), .Output(g2), .Binary(b2), .Overflow(o2), .Underflow(u2), .Wrap(w2)
    );

    // Reference model: plain modular arithmetic on an integer count per instance.
    int m_w[3]      = '{4, 4, 3};
    bit m_sticky[3] = '{1'b1, 1'b0, 1'b1};
    int m_b[3], m_o[3], m_u[3], m_wr[3];
    int prev_g[3];

    function automatic int to_gray(input int v);
        return v ^ (v >> 1);
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 3; i++) begin
            int mask;
            int eo;
            int eu;
            mask = (1 << m_w[i]) - 1;
            eo = 0;
            eu = 0;
            if (rst) begin
                m_b[i] = 0; m_o[i] = 0; m_u[i] = 0; m_wr[i] = 0;
            end else begin
                if (load) begin
                    m_b[i] = int'(lv) & mask;
                end else if (en) begin
                    if (dir) begin
                        eo = (m_b[i] == mask) ? 1 : 0;
                        m_b[i] = (m_b[i] + 1) & mask;
                    end else begin
                        eu = (m_b[i] == 0) ? 1 : 0;
                        m_b[i] = (m_b[i] - 1) & mask;
                    end
                end
                m_wr[i] = eo | eu;
                if (m_sticky[i]) begin
                    m_o[i] = eo | ((m_o[i] != 0 && !clr) ? 1 : 0);
                    m_u[i] = eu | ((m_u[i] != 0 && !clr) ? 1 : 0);
                end else begin
                    m_o[i] = eo;
                    m_u[i] = eu;
                end
            end
        end
    endtask

    task automatic check_model(input bit counting);
        int ag[3], ab[3], ao[3], au[3], aw[3];
        ag = '{int'(g0), int'(g1), int'(g2)};
        ab = '{int'(b0), int'(b1), int'(b2)};
        ao = '{int'(o0), int'(o1), int'(o2)};
        au = '{int'(u0), int'(u1), int'(u2)};
        aw = '{int'(w0), int'(w1), int'(w2)};
        for (int i = 0; i < 3; i++) begin
            cmp($sformatf("model_bin[%0d]", i), ab[i], m_b[i]);
            cmp($sformatf("model_gray[%0d]", i), ag[i], to_gray(m_b[i]));
            cmp($sformatf("model_ovf[%0d]", i), ao[i], m_o[i]);
            cmp($sformatf("model_unf[%0d]", i), au[i], m_u[i]);
            cmp($sformatf("model_wrap[%0d]", i), aw[i], m_wr[i]);
            if (counting)
                cmp($sformatf("hamming[%0d]", i), $countones(ag[i] ^ prev_g[i]), 1);
            prev_g[i] = ag[i];
        end
    endtask

    // One clock: model follows the inputs present at the edge, outputs sampled 1ns later.
    task automatic step();
        bit counting;
        counting = !rst && !load && en;
        @(posedge clk);
        model_update();
        #1;
        check_model(counting);
    endtask

    task automatic drive(input bit r, input bit e, input bit d, input bit l,
                         input logic [3:0] v, input bit c);
        rst = r; en = e; dir = d; load = l; lv = v; clr = c;
    endtask

    typedef struct {
        bit         r, e, d, l;
        logic [3:0] v;
        bit         c;
        logic [3:0] xb, xg;
        bit         xo, xu, xw;
    } vec_t;

    vec_t vecs[16];

    initial begin
        drive(1, 0, 0, 0, 4'h0, 0);
        prev_g = '{0, 0, 0};

        //           r  e  d  l  v      c  bin    gray   o  u  w
        vecs[0]  = '{1, 0, 0, 0, 4'h0,  0, 4'h0,  4'h0,  0, 0, 0};
        vecs[1]  = '{0, 1, 0, 0, 4'h0,  0, 4'hF,  4'h8,  0, 1, 1};
        vecs[2]  = '{0, 1, 1, 1, 4'h5,  0, 4'h5,  4'h7,  0, 1, 0};
        vecs[3]  = '{0, 1, 1, 0, 4'h0,  0, 4'h6,  4'h5,  0, 1, 0};
        vecs[4]  = '{0, 0, 0, 0, 4'h0,  1, 4'h6,  4'h5,  0, 0, 0};
        vecs[5]  = '{0, 0, 0, 1, 4'hF,  0, 4'hF,  4'h8,  0, 0, 0};
        vecs[6]  = '{0, 1, 1, 0, 4'h0,  1, 4'h0,  4'h0,  1, 0, 1};
        vecs[7]  = '{0, 0, 0, 0, 4'h0,  1, 4'h0,  4'h0,  0, 0, 0};
        vecs[8]  = '{0, 0, 0, 1, 4'hA,  0, 4'hA,  4'hF,  0, 0, 0};
        vecs[9]  = '{1, 1, 1, 1, 4'h3,  0, 4'h0,  4'h0,  0, 0, 0};
        vecs[10] = '{0, 0, 0, 0, 4'h0,  0, 4'h0,  4'h0,  0, 0, 0};
        vecs[11] = '{0, 0, 1, 0, 4'h0,  0, 4'h0,  4'h0,  0, 0, 0};
        vecs[12] = '{0, 1, 0, 0, 4'h0,  0, 4'hF,  4'h8,  0, 1, 1};
        vecs[13] = '{0, 1, 0, 0, 4'h0,  0, 4'hE,  4'h9,  0, 1, 0};
        vecs[14] = '{0, 1, 1, 0, 4'h0,  0, 4'hF,  4'h8,  0, 1, 0};
        vecs[15] = '{0, 1, 1, 0, 4'h0,  0, 4'h0,  4'h0,  1, 1, 1};

        step();

        for (int k = 0; k < 16; k++) begin
            drive(vecs[k].r, vecs[k].e, vecs[k].d, vecs[k].l, vecs[k].v, vecs[k].c);
            step();
            cmp($sformatf("vec%0d_bin", k), int'(b0), int'(vecs[k].xb));
            cmp($sformatf("vec%0d_gray", k), int'(g0), int'(vecs[k].xg));
            cmp($sformatf("vec%0d_ovf", k), int'(o0), int'(vecs[k].xo));
            cmp($sformatf("vec%0d_unf", k), int'(u0), int'(vecs[k].xu));
            cmp($sformatf("vec%0d_wrap", k), int'(w0), int'(vecs[k].xw));
        end

        // 3-bit up count through a full cycle, including the wrap to zero.
        begin
            int seq[8];
            seq = '{1, 3, 2, 6, 7, 5, 4, 0};
            drive(1, 0, 0, 0, 4'h0, 0);
            step();
            for (int k = 0; k < 8; k++) begin
                drive(0, 1, 1, 0, 4'h0, 0);
                step();
                cmp($sformatf("w3_seq%0d", k), int'(g2), seq[k]);
                cmp($sformatf("w3_ovf%0d", k), int'(o2), (k == 7) ? 1 : 0);
                cmp($sformatf("w3_wrap%0d", k), int'(w2), (k == 7) ? 1 : 0);
            end
            drive(0, 0, 0, 0, 4'h0, 0);
            step();
            cmp("w3_wrap_after", int'(w2), 0);
            cmp("w3_ovf_held", int'(o2), 1);
        end

        // Pulsed flags: overflow lasts one cycle and ignores ClrFlags.
        drive(0, 0, 0, 1, 4'hE, 0);
        step();
        drive(0, 1, 1, 0, 4'h0, 0);
        step();
        cmp("pulse_pre_ovf", int'(o1), 0);
        step();
        cmp("pulse_ovf", int'(o1), 1);
        cmp("pulse_bin", int'(b1), 0);
        drive(0, 1, 1, 0, 4'h0, 1);
        step();
        cmp("pulse_ovf_drop", int'(o1), 0);
        drive(0, 0, 0, 0, 4'h0, 0);
        step();
        cmp("pulse_ovf_stay", int'(o1), 0);

        // Random traffic against the reference model.
        for (int k = 0; k < 500; k++) begin
            drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) != 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 7) == 0,
                  4'($urandom_range(0, 15)), $urandom_range(0, 7) == 0);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
